serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor, the inverse operation of the parallel adder.
//   Accepts operands a, b on a valid/ready handshake and resolves one bit per clock, LSB first.
//   Returns diff = (a - b) mod 2^WIDTH and borrow-out bout (1 when a < b) on a
//   valid/ready output handshake.
//   Sits beside the adder datapath where area is tight and multi-cycle latency is acceptable.
// PARAMETERS
//   WIDTH   4   operand/result width in bits (>= 1)
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   rst        in   1      synchronous reset, active high
//   in_valid   in   1      operand pair a/b valid
//   in_ready   out  1      block can accept operands
//   a          in   WIDTH  minuend (unsigned)
//   b          in   WIDTH  subtrahend (unsigned)
//   out_valid  out  1      diff/bout valid
//   out_ready  in   1      downstream accepts result
//   diff       out  WIDTH  a - b modulo 2^WIDTH
//   bout       out  1      final borrow; 1 iff a < b
// BEHAVIOUR
//   Reset: one clock only; reset is synchronous and active-high (rst sampled on rising edge of clk).
//     state=IDLE; in_ready=1; out_valid=0; diff=0; bout=0; internal borrow/index/shift regs=0.
//     rst overrides every other input, including a mid-RUN or mid-DONE transaction, which is discarded.
//   FSM states: IDLE, RUN, DONE.
//   IDLE:
//     in_ready=1, out_valid=0.
//     On in_valid && in_ready: latch a, b; borrow=0; idx=0; clear the diff accumulator; go to RUN.
//   RUN:
//     in_ready=0; in_valid ignored.
//     Each cycle, bit idx: d = a[idx]^b[idx]^brw; brw' = (~a[idx]&b[idx]) | (~a[idx]&brw) | (b[idx]&brw).
//     Store d into diff accumulator bit idx; idx++.
//     After the cycle that processes idx=WIDTH-1, go to DONE.
//   DONE:
//     out_valid=1; diff and bout=brw presented from registers.
//     diff and bout are held stable while out_ready=0, for any number of cycles.
//     On out_valid && out_ready: go to IDLE and deassert out_valid next cycle.
//     diff/bout keep their last value, which is don't-care when out_valid=0.
//   Latency: acceptance edge at cycle T -> out_valid first high after edge T+WIDTH.
//     Throughput: one result per WIDTH+2 cycles with out_ready tied high.
//   in_ready is a registered function of state only (high only in IDLE).
//     There is no combinational path from out_ready to in_ready.
//     Outputs are registered, with no combinational path from inputs to outputs.
//   Width rules: idx counter is clog2(WIDTH+1) bits wide; WIDTH=1 completes RUN in a single cycle.
//   a and b are sampled only at acceptance; changes afterwards have no effect.
// TESTING
//   WIDTH=4: a=9, b=4 -> out_valid 4 cycles after accept; diff=5, bout=0.
//   a=3, b=5 -> diff=14, bout=1. a=0, b=15 -> diff=1, bout=1. a=15, b=15 -> diff=0, bout=0.
//   Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1; diff/bout unchanged; in_ready=0 throughout.
//   Pulse in_valid with new operands during RUN -> ignored; the result matches the first operands only.
//   Assert rst in RUN cycle 2 -> next cycle state IDLE, in_ready=1, out_valid=0.
//     A fresh 7-2 then returns diff=5.
//   Randomised 1000 transactions, WIDTH=4 and WIDTH=1, random in_valid/out_ready stalls -> every result
//     equals a reference {bout,diff} = {1'b0,a} - {1'b0,b}.
//     Every result has exactly one out handshake per in handshake, in order.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: accepts a/b on a valid/ready handshake, resolves one
// difference bit per clock (LSB first) and returns diff = a - b mod 2^WIDTH plus borrow-out.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned IdxW = $clog2(WIDTH + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             brw_q;
    logic [IdxW-1:0]  idx_q;

    logic             dbit;
    logic             brw_d;
    logic [WIDTH-1:0] diff_d;

    // Operands are shifted right each RUN cycle, so bit 0 is always the current bit;
    // the difference shifts in from the top and lands LSB-aligned after WIDTH cycles.
    always_comb begin
        dbit   = a_q[0] ^ b_q[0] ^ brw_q;
        brw_d  = (~a_q[0] & b_q[0]) | (~a_q[0] & brw_q) | (b_q[0] & brw_q);
        diff_d = (diff >> 1) | (WIDTH'(dbit) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            brw_q     <= 1'b0;
            idx_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        brw_q    <= 1'b0;
                        idx_q    <= '0;
                        diff     <= '0;
                        in_ready <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    brw_q <= brw_d;
                    diff  <= diff_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        bout      <= brw_d;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases at WIDTH=4 and WIDTH=1, then
// randomised stalled traffic on both widths against an arithmetic reference with queues.
module tb_serial_subtractor;

    localparam int N = 1000;
    localparam int MaxCycles = 60000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv4, ir4, ov4, or4, bo4;
    logic [3:0] a4, b4, d4;
    logic       iv1, ir1, ov1, or1, bo1;
    logic [0:0] a1, b1, d1;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (iv4),
        .in_ready (ir4),
        .a        (a4),
        .b        (b4),
        .out_valid(ov4),
        .out_ready(or4),
        .diff     (d4),
        .bout     (bo4)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (iv1),
        .in_ready (ir1),
        .a        (a1),
        .b        (b1),
        .out_valid(ov1),
        .out_ready(or1),
        .diff     (d1),
        .bout     (bo1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=4 transaction with fixed latency checks, optional DONE stall and RUN poke.
    task automatic xfer4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] ed,
                         input logic eb, input int hold, input bit poke);
        chk("idle_in_ready", 32'(ir4), 1);
        iv4 = 1'b1;
        a4  = a;
        b4  = b;
        or4 = 1'b0;
        step();
        iv4 = 1'b0;
        chk("run_in_ready", 32'(ir4), 0);
        if (poke) begin
            iv4 = 1'b1;
            a4  = ~a;
            b4  = a;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            iv4 = 1'b0;
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            chk("latency_early", 32'(ov4), 0);
        end
        step();
        chk("latency_valid", 32'(ov4), 1);
        chk("diff", 32'(d4), 32'(ed));
        chk("bout", 32'(bo4), 32'(eb));
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", 32'(ov4), 1);
            chk("hold_result", 32'({bo4, d4}), 32'({eb, ed}));
            chk("hold_in_ready", 32'(ir4), 0);
        end
        or4 = 1'b1;
        step();
        or4 = 1'b0;
        chk("out_drop", 32'(ov4), 0);
        chk("ready_back", 32'(ir4), 1);
    endtask

    logic [4:0] q4[$];
    logic [1:0] q1[$];
    int acc4, got4, acc1, got1, cyc, stray;

    initial begin
        rst = 1'b1;
        iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
        iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;
        step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(ir4), 1);
        chk("rst_out_valid", 32'(ov4), 0);
        chk("rst_diff", 32'(d4), 0);
        chk("rst_bout", 32'(bo4), 0);
        chk("rst_w1_in_ready", 32'(ir1), 1);
        chk("rst_w1_out_valid", 32'(ov1), 0);

        xfer4(4'd9, 4'd4, 4'd5, 1'b0, 0, 1'b0);
        xfer4(4'd3, 4'd5, 4'd14, 1'b1, 0, 1'b0);
        xfer4(4'd0, 4'd15, 4'd1, 1'b1, 0, 1'b0);
        xfer4(4'd15, 4'd15, 4'd0, 1'b0, 0, 1'b0);
        xfer4(4'd12, 4'd7, 4'd5, 1'b0, 10, 1'b0);
        xfer4(4'd6, 4'd11, 4'd11, 1'b1, 0, 1'b1);

        // Reset while in RUN cycle 2 discards the transaction.
        iv4 = 1'b1; a4 = 4'd9; b4 = 4'd4;
        step();
        iv4 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_rst_in_ready", 32'(ir4), 1);
        chk("midrun_rst_out_valid", 32'(ov4), 0);
        xfer4(4'd7, 4'd2, 4'd5, 1'b0, 0, 1'b0);

        // WIDTH=1 completes RUN in a single cycle.
        iv1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        step();
        iv1 = 1'b0;
        chk("w1_early", 32'(ov1), 0);
        step();
        chk("w1_valid", 32'(ov1), 1);
        chk("w1_result", 32'({bo1, d1}), 32'(2'b11));
        or1 = 1'b1;
        step();
        or1 = 1'b0;
        chk("w1_drop", 32'(ov1), 0);

        acc4 = 0; got4 = 0; acc1 = 0; got1 = 0; cyc = 0;
        while ((got4 < N || got1 < N) && cyc < MaxCycles) begin
            iv4 = (acc4 < N) && ($urandom_range(3) != 0);
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            or4 = ($urandom_range(3) != 0);
            iv1 = (acc1 < N) && ($urandom_range(3) != 0);
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            or1 = ($urandom_range(3) != 0);
            #1;
            if (iv4 && ir4) begin
                q4.push_back({1'b0, a4} - {1'b0, b4});
                acc4++;
            end
            if (ov4 && or4) begin
                if (q4.size() == 0) chk("rnd4_spurious", 1, 0);
                else chk("rnd4_result", 32'({bo4, d4}), 32'(q4.pop_front()));
                got4++;
            end
            if (iv1 && ir1) begin
                q1.push_back({1'b0, a1} - {1'b0, b1});
                acc1++;
            end
            if (ov1 && or1) begin
                if (q1.size() == 0) chk("rnd1_spurious", 1, 0);
                else chk("rnd1_result", 32'({bo1, d1}), 32'(q1.pop_front()));
                got1++;
            end
            step();
            cyc++;
        end
        chk("rnd4_count", 32'(got4), N);
        chk("rnd1_count", 32'(got1), N);
        chk("rnd4_queue_empty", 32'(q4.size()), 0);
        chk("rnd1_queue_empty", 32'(q1.size()), 0);

        iv4 = 1'b0; iv1 = 1'b0; or4 = 1'b1; or1 = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ov4 || ov1) stray++;
        end
        chk("no_extra_outputs", 32'(stray), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
